// File: rtl/coreaxi4dma_dscrptr_req_queue.sv
// coreaxi4dma_dscrptr_req_queue: buffers descriptor-start events in a small FIFO and
// presents the head as a held request to one fixed-priority arbiter input.
`default_nettype none

module coreaxi4dma_dscrptr_req_queue #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH_LOG2   = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         startValid,
  input  logic [NUM_INT_BDS_WIDTH-1:0] startDscrptrNum,
  input  logic                         startStr,
  input  logic                         grant,
  input  logic                         opDone,
  output logic                         req,
  output logic [NUM_INT_BDS_WIDTH-1:0] reqDscrptrNum,
  output logic                         reqStr,
  output logic                         busy,
  output logic [NUM_INT_BDS_WIDTH-1:0] actDscrptrNum,
  output logic                         actStr,
  output logic [FIFO_DEPTH_LOG2:0]     level,
  output logic                         empty,
  output logic                         full,
  output logic                         overflowErr
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int EW    = NUM_INT_BDS_WIDTH + 1;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [EW-1:0]                mem [DEPTH];
  logic [1:0]                   state_q, state_d;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic                         empty_q, full_q;
  logic                         req_q, req_d;
  logic                         busy_q, busy_d;
  logic [NUM_INT_BDS_WIDTH-1:0] act_num_q, act_num_d;
  logic                         act_str_q, act_str_d;
  logic                         ovf_q, ovf_d;
  logic                         push, pop;
  logic [EW-1:0]                head;

  assign head = mem[rd_ptr_q];
  assign pop  = (state_q == S_REQ) && grant;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = startValid && (!full_q || pop);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    state_d   = state_q;
    act_num_d = act_num_q;
    act_str_d = act_str_q;
    ovf_d     = startValid && !push;

    if (push) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (!empty_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (grant) begin
          state_d   = S_ACTIVE;
          act_num_d = head[NUM_INT_BDS_WIDTH-1:0];
          act_str_d = head[EW-1];
        end
      end
      S_ACTIVE: begin
        if (opDone) state_d = (level_d != '0) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_REQ);
    busy_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {startStr, startDscrptrNum};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      act_num_q <= '0;
      act_str_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      empty_q   <= (level_d == '0);
      full_q    <= (level_d == LEVEL_FULL);
      req_q     <= req_d;
      busy_q    <= busy_d;
      act_num_q <= act_num_d;
      act_str_q <= act_str_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset, so the head is masked while nothing is queued.
  assign reqDscrptrNum = empty_q ? '0 : head[NUM_INT_BDS_WIDTH-1:0];
  assign reqStr        = empty_q ? 1'b0 : head[EW-1];
  assign req           = req_q;
  assign busy          = busy_q;
  assign actDscrptrNum = act_num_q;
  assign actStr        = act_str_q;
  assign level         = level_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign overflowErr   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_coreaxi4dma_dscrptr_req_queue.sv
// Testbench for coreaxi4dma_dscrptr_req_queue: directed stimulus with a scoreboard of
// expected granted descriptors checked by an independent monitor.
`default_nettype none

module tb_coreaxi4dma_dscrptr_req_queue;

  localparam int W  = 2;
  localparam int LG = 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          startValid = 1'b0;
  logic [W-1:0]  startDscrptrNum = '0;
  logic          startStr = 1'b0;
  logic          grant = 1'b0;
  logic          opDone = 1'b0;
  logic          req;
  logic [W-1:0]  reqDscrptrNum;
  logic          reqStr;
  logic          busy;
  logic [W-1:0]  actDscrptrNum;
  logic          actStr;
  logic [LG:0]   level;
  logic          empty;
  logic          full;
  logic          overflowErr;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  always #5 clock = ~clock;

  coreaxi4dma_dscrptr_req_queue #(
    .NUM_INT_BDS_WIDTH(W),
    .FIFO_DEPTH_LOG2(LG)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .startValid(startValid),
    .startDscrptrNum(startDscrptrNum),
    .startStr(startStr),
    .grant(grant),
    .opDone(opDone),
    .req(req),
    .reqDscrptrNum(reqDscrptrNum),
    .reqStr(reqStr),
    .busy(busy),
    .actDscrptrNum(actDscrptrNum),
    .actStr(actStr),
    .level(level),
    .empty(empty),
    .full(full),
    .overflowErr(overflowErr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issued descriptor is whatever the head shows when a grant is about to be taken.
  always @(negedge clock) begin
    if (resetn && req && grant) begin
      logic [W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_order: got {%0d,%0d} with nothing expected", reqStr, reqDscrptrNum);
      end else begin
        e = exp_q.pop_front();
        if ({reqStr, reqDscrptrNum} != e) begin
          errors++;
          $display("FAIL issue_order: got {%0d,%0d} expected {%0d,%0d}",
                   reqStr, reqDscrptrNum, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic set_push(input int num, input bit str, input bit expect_accept);
    startValid      = 1'b1;
    startDscrptrNum = W'(num);
    startStr        = str;
    if (expect_accept) exp_q.push_back({str, W'(num)});
  endtask

  initial begin
    int drain_exp [4] = '{1, 2, 3, 3};

    // Reset state
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_act", int'(actDscrptrNum), 0);
    chk("rst_ovf", int'(overflowErr), 0);

    // Single push, grant, opDone
    set_push(2, 1'b0, 1'b1);
    tick();
    startValid = 1'b0;
    chk("t1_level", int'(level), 1);
    chk("t1_req_early", int'(req), 0);
    tick();
    chk("t1_req", int'(req), 1);
    chk("t1_reqnum", int'(reqDscrptrNum), 2);
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("t1_g_req", int'(req), 0);
    chk("t1_g_busy", int'(busy), 1);
    chk("t1_g_act", int'(actDscrptrNum), 2);
    chk("t1_g_empty", int'(empty), 1);
    tick();
    tick();
    opDone = 1'b1;
    tick();
    opDone = 1'b0;
    chk("t1_d_busy", int'(busy), 0);
    chk("t1_d_req", int'(req), 0);
    tick();
    chk("t1_idle_req", int'(req), 0);

    // Fill, overflow
    for (int i = 0; i < 4; i++) begin
      set_push(i, 1'b0, 1'b1);
      tick();
    end
    set_push(1, 1'b1, 1'b0);
    tick();
    startValid = 1'b0;
    chk("t2_full", int'(full), 1);
    chk("t2_level", int'(level), 4);
    chk("t2_ovf", int'(overflowErr), 1);
    tick();
    chk("t2_ovf_clr", int'(overflowErr), 0);
    chk("t2_level_hold", int'(level), 4);
    chk("t2_req", int'(req), 1);

    // Full FIFO: push and pop on the same edge
    set_push(3, 1'b0, 1'b1);
    grant = 1'b1;
    tick();
    startValid = 1'b0;
    grant = 1'b0;
    chk("t3_level", int'(level), 4);
    chk("t3_ovf", int'(overflowErr), 0);
    chk("t3_busy", int'(busy), 1);
    chk("t3_act", int'(actDscrptrNum), 0);

    for (int i = 0; i < 4; i++) begin
      opDone = 1'b1;
      tick();
      opDone = 1'b0;
      chk("t3_rereq", int'(req), 1);
      chk("t3_nobusy", int'(busy), 0);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      chk("t3_drain_act", int'(actDscrptrNum), drain_exp[i]);
    end
    opDone = 1'b1;
    tick();
    opDone = 1'b0;
    chk("t3_end_req", int'(req), 0);
    chk("t3_end_busy", int'(busy), 0);
    chk("t3_end_empty", int'(empty), 1);

    // Back-to-back with two queued, plus ignored grant/opDone
    set_push(1, 1'b1, 1'b1);
    tick();
    set_push(2, 1'b0, 1'b1);
    tick();
    startValid = 1'b0;
    chk("t4_req", int'(req), 1);
    chk("t4_reqnum", int'(reqDscrptrNum), 1);
    chk("t4_reqstr", int'(reqStr), 1);
    grant = 1'b1;
    tick();
    chk("t4_act", int'(actDscrptrNum), 1);
    chk("t4_actstr", int'(actStr), 1);
    tick();
    grant = 1'b0;
    chk("t4_ga_level", int'(level), 1);
    chk("t4_ga_req", int'(req), 0);
    chk("t4_ga_busy", int'(busy), 1);
    chk("t4_ga_act", int'(actDscrptrNum), 1);
    opDone = 1'b1;
    tick();
    chk("t4_d_req", int'(req), 1);
    chk("t4_d_reqnum", int'(reqDscrptrNum), 2);
    chk("t4_d_reqstr", int'(reqStr), 0);
    chk("t4_d_busy", int'(busy), 0);
    tick();
    opDone = 1'b0;
    chk("t4_dr_req", int'(req), 1);
    chk("t4_dr_level", int'(level), 1);
    chk("t4_dr_busy", int'(busy), 0);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("t4_act2", int'(actDscrptrNum), 2);
    chk("t4_actstr2", int'(actStr), 0);
    opDone = 1'b1;
    tick();
    opDone = 1'b0;
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("t4_gi_level", int'(level), 0);
    chk("t4_gi_req", int'(req), 0);
    chk("t4_gi_busy", int'(busy), 0);
    chk("t4_gi_act", int'(actDscrptrNum), 2);

    // Asynchronous reset while active with two entries pending
    for (int i = 0; i < 3; i++) begin
      set_push(i, 1'b0, 1'b1);
      tick();
    end
    startValid = 1'b0;
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("t5_busy_pre", int'(busy), 1);
    chk("t5_level_pre", int'(level), 2);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_req", int'(req), 0);
    chk("t5_level", int'(level), 0);
    chk("t5_empty", int'(empty), 1);
    tick();
    #2;
    resetn = 1'b1;
    repeat (3) tick();
    chk("t5_noreq", int'(req), 0);
    chk("t5_level_post", int'(level), 0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/coreaxi4dma_dscrptr_req_queue.md
# coreaxi4dma_dscrptr_req_queue

Requester-side front end for the DMA controller's fixed-priority descriptor arbiter. It accepts descriptor-start events from one source, internal or stream, and buffers them in a small FIFO. It presents the head entry to its arbiter input as a held request and pops the entry when the grant arrives. It then tracks the granted operation until the engine reports completion before raising the next request. One instance sits on each arbiter request line.

## Interface
- `NUM_INT_BDS_WIDTH`, 2, width of a descriptor number
- `FIFO_DEPTH_LOG2`, 2, log2 of FIFO depth; depth = 2^FIFO_DEPTH_LOG2 (default 4 entries)
- `clock`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `startValid`  in  1  one-cycle start event; push request
- `startDscrptrNum`  in  NUM_INT_BDS_WIDTH  descriptor number of the start event
- `startStr`  in  1  start event is a stream descriptor
- `grant`  in  1  arbiter grant for this requester (may be combinational from `req`)
- `opDone`  in  1  one-cycle pulse: granted operation finished
- `req`  out  1  registered request to arbiter
- `reqDscrptrNum`  out  NUM_INT_BDS_WIDTH  FIFO head descriptor number, meaningful while `req`=1
- `reqStr`  out  1  FIFO head stream flag, meaningful while `req`=1
- `busy`  out  1  granted operation outstanding
- `actDscrptrNum`  out  NUM_INT_BDS_WIDTH  descriptor number of the granted operation
- `actStr`  out  1  stream flag of the granted operation
- `level`  out  FIFO_DEPTH_LOG2+1  FIFO occupancy 0..depth
- `empty`, `full`  out  1  occupancy flags (`level`==0 / `level`==depth)
- `overflowErr`  out  1  one-cycle pulse: start event dropped

## Operation
- FIFO entry = {str, dscrptrNum}. Read pointer and write pointer are FIFO_DEPTH_LOG2 bits and wrap naturally. `level` is a separate counter.
- Push accepted when `startValid` && (!`full` || pop this cycle). Otherwise the event is dropped, `overflowErr`=1 for one cycle, and FIFO state is unchanged.
- Pop = state REQ && `grant`. When push and pop occur in the same cycle, `level` is unchanged.
- FSM states: IDLE, REQ, ACTIVE. `req` = (state==REQ), registered.
  - IDLE: !`empty` -> REQ; else stay.
  - REQ: `grant` -> ACTIVE. On the same edge, capture the head into `actDscrptrNum`/`actStr`, pop, and set `busy`=1. Otherwise hold REQ. The head is stable while waiting.
  - ACTIVE: `opDone` -> (`level` after this cycle's push/pop != 0 ? REQ : IDLE), with `busy` cleared. Otherwise stay.
- `grant` outside REQ is ignored, with no pop and no state change. `opDone` outside ACTIVE is ignored.
- `reqDscrptrNum`/`reqStr` are driven from the FIFO head at all times. Consumers qualify them with `req`.
- Reset values: state IDLE, pointers 0, `level`=0, `empty`=1, `full`=0, `req`=0, `busy`=0, `actDscrptrNum`=0, `actStr`=0, `overflowErr`=0. FIFO storage is not reset, but outputs read as zero until the first push.
- Reset asserted mid-operation: the queue and the active operation are discarded. `req` and `busy` drop asynchronously.

## Timing
- Push sampled at edge k: `level`/`empty` update after edge k. IDLE->REQ at edge k+1, so `req`=1 from edge k+1. Minimum start-to-request latency is 2 cycles.
- `grant` sampled at edge g: `req`=0 and `busy`=1 after edge g. The grant is sampled while `req`=1, so the arbiter may assert it combinationally in the same cycle.
- `opDone` at edge d with entries pending: `req`=1 after edge d, so there is no idle cycle between operations. With nothing pending, the next push needs the full 2-cycle latency.
- `overflowErr` is asserted in the cycle following the dropped push edge, for exactly one cycle.
- A push in the same cycle as the IDLE->REQ decision does not change the head when the FIFO was already non-empty.

## Test plan
- Reset then a single push {num=2, str=0} at edge 1 -> `level`=1 after edge 1; `req`=1 and `reqDscrptrNum`=2 after edge 2. Grant at edge 4 -> `req`=0, `busy`=1, `actDscrptrNum`=2, `empty`=1. `opDone` at edge 7 -> `busy`=0, state IDLE.
- Push nums 0,1,2,3 on consecutive cycles with no grant -> `full`=1, `level`=4. A 5th push -> `overflowErr` pulses for one cycle and `level` stays 4. Grant each entry -> descriptors are issued in order 0,1,2,3.
- Full FIFO with push {3} and grant in the same cycle while in REQ -> `level` stays 4, no `overflowErr`, and the last entry drained is 3.
- Two entries queued: grant, then `opDone` -> `req` reasserts the edge after `opDone`, with `reqDscrptrNum` equal to the second entry.
- `grant` pulsed while IDLE or ACTIVE, and `opDone` pulsed while REQ -> no change to `level`, `req`, `busy` or `act*`.
- Deassert `resetn` while ACTIVE with 2 entries queued -> `busy`=0, `req`=0, `level`=0 and `empty`=1 immediately. After release there is no request until a new push.
